// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data memory arbiter
//
// Holds the owner enum, the port ID encoding and the default parameter values
// used by dmem_arbiter and dmem_arb_pick. No ports.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 14;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_A    = 2'd1,
    PORT_B    = 2'd2
  } port_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational round-robin port selection
//
// Ports:
//   reqs   in  2        {b_req, a_req}
//   owner  in  owner_t  current owner
//   cnt    in  4        consecutive grants to the current owner
//   last   in  port_t   port that most recently took ownership
//   sel    out port_t   selected port (PORT_NONE when nobody requests)
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic [1:0] reqs,
  input  owner_t     owner,
  input  logic [3:0] cnt,
  input  port_t      last,
  output port_t      sel
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  always_comb begin
    sel = PORT_NONE;
    case (reqs)
      2'b01: sel = PORT_A;
      2'b10: sel = PORT_B;
      2'b11: begin
        // The owner keeps the RAM until its burst budget is spent; after that
        // the port that did not take ownership most recently wins.
        if (owner == OWN_A && cnt < MAX_B)      sel = PORT_A;
        else if (owner == OWN_B && cnt < MAX_B) sel = PORT_B;
        else                                    sel = (last == PORT_A) ? PORT_B : PORT_A;
      end
      default: sel = PORT_NONE;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of the data RAM
//
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN (reject misaligned accesses).
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   a_*/b_* req/we/addr/wdata    requester inputs (byte addresses)
//   a_*/b_* gnt                  same-cycle grant
//   a_*/b_* rvalid/rdata         read response one cycle after the grant
//   a_*/b_* err                  misaligned access flag (macro only, else 0)
//   ram_we/ram_addr/ram_wdata    RAM command, from the selected port
//   ram_rdata                    RAM read data for the previous cycle's address
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              a_err,
  output logic              b_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  owner_t      owner;
  logic [3:0]  cnt;
  port_t       last;
  port_t       sel;

  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              aligned;
  logic              same_owner;
  logic              unused_addr_bits;

  dmem_arb_pick #(
    .MAX_BURST(MAX_BURST)
  ) u_pick (
    .reqs  ({b_req, a_req}),
    .owner (owner),
    .cnt   (cnt),
    .last  (last),
    .sel   (sel)
  );

  assign a_gnt = (sel == PORT_A);
  assign b_gnt = (sel == PORT_B);

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (sel)
      PORT_A: begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
      end
      PORT_B: begin
        sel_we    = b_we;
        sel_addr  = b_addr;
        sel_wdata = b_wdata;
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign aligned = (sel_addr[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  // A misaligned access is still granted but must never reach the RAM.
  assign ram_we    = sel_we & aligned;
  assign ram_addr  = sel_addr[ADDR_W+1:2];
  assign ram_wdata = sel_wdata;

  assign a_rdata = ram_rdata;
  assign b_rdata = ram_rdata;

  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

  assign same_owner = (sel == PORT_A && owner == OWN_A) ||
                      (sel == PORT_B && owner == OWN_B);

  always_ff @(posedge clock) begin
    if (reset) begin
      owner    <= IDLE;
      cnt      <= 4'd0;
      last     <= PORT_B;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      if (sel == PORT_NONE) begin
        owner <= IDLE;
        cnt   <= 4'd0;
      end else if (same_owner) begin
        if (cnt != 4'hF) cnt <= cnt + 4'd1;
      end else begin
        owner <= (sel == PORT_A) ? OWN_A : OWN_B;
        cnt   <= 4'd1;
        last  <= sel;
      end
      a_rvalid <= a_gnt & ~a_we & aligned;
      b_rvalid <= b_gnt & ~b_we & aligned;
      a_err    <= a_gnt & ~aligned;
      b_err    <= b_gnt & ~aligned;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              a_req, a_we, b_req, b_we;
  logic [31:0]       a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: which port holds the current run, its length, and the
  // port that most recently started a run.
  int m_run_port, m_run_len, m_last;
  bit e_arv, e_brv, e_aerr, e_berr;
  logic [DATA_W-1:0] e_rd;
  logic obs_a_gnt, obs_b_gnt, obs_ram_we;
  logic [ADDR_W-1:0] obs_ram_addr;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .a_err(a_err), .b_err(b_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run_port = 0;
    m_run_len  = 0;
    m_last     = 2;
    e_arv = 0; e_brv = 0; e_aerr = 0; e_berr = 0;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
    a_req = req; a_we = we; a_addr = addr; a_wdata = data;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
    b_req = req; b_we = we; b_addr = addr; b_wdata = data;
  endtask

  // One clock cycle: check same-cycle outputs against the reference, clock,
  // then check the registered response predicted for the cycle just issued.
  task automatic do_cycle(input bit rst);
    int sel;
    logic s_we;
    logic [31:0] s_addr, s_wdata;
    bit mis, issue;
    reset = rst;
    #2;
    if (a_req && b_req) begin
      if (m_run_port != 0 && m_run_len < MAX_BURST) sel = m_run_port;
      else sel = (m_last == 1) ? 2 : 1;
    end else if (a_req) sel = 1;
    else if (b_req) sel = 2;
    else sel = 0;
    s_we = 0; s_addr = 0; s_wdata = 0;
    if (sel == 1) begin s_we = a_we; s_addr = a_addr; s_wdata = a_wdata; end
    if (sel == 2) begin s_we = b_we; s_addr = b_addr; s_wdata = b_wdata; end
    mis   = ALIGN && (sel != 0) && (s_addr[1:0] != 2'b00);
    issue = (sel != 0) && !mis;

    chk("a_gnt", a_gnt, sel == 1);
    chk("b_gnt", b_gnt, sel == 2);
    chk("ram_we", ram_we, issue && s_we);
    chk("ram_addr", ram_addr, s_addr[ADDR_W+1:2]);
    chk("ram_wdata", ram_wdata, s_wdata);
    obs_a_gnt = a_gnt; obs_b_gnt = b_gnt;
    obs_ram_we = ram_we; obs_ram_addr = ram_addr;

    e_arv  = (sel == 1) && !s_we && !mis;
    e_brv  = (sel == 2) && !s_we && !mis;
    e_aerr = (sel == 1) && mis;
    e_berr = (sel == 2) && mis;
    e_rd   = ref_mem[s_addr[ADDR_W+1:2]];
    if (issue && s_we) ref_mem[s_addr[ADDR_W+1:2]] = s_wdata;

    if (sel == 0) begin
      m_run_port = 0; m_run_len = 0;
    end else if (sel == m_run_port) begin
      if (m_run_len < 15) m_run_len++;
    end else begin
      m_run_port = sel; m_run_len = 1; m_last = sel;
    end

    @(posedge clock);
    #1;
    if (rst) model_reset();
    reset = 1'b0;
    chk("a_rvalid", a_rvalid, e_arv);
    chk("b_rvalid", b_rvalid, e_brv);
    chk("a_err", a_err, e_aerr);
    chk("b_err", b_err, e_berr);
    if (e_arv) chk("a_rdata", a_rdata, e_rd);
    if (e_brv) chk("b_rdata", b_rdata, e_rd);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    reset = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_err", b_err, 0);

    // Single read from A at byte 0x10.
    set_a(1, 0, 32'h10, 0);
    do_cycle(0);
    chk("read10_addr", obs_ram_addr, 4);
    set_a(0, 0, 0, 0);
    do_cycle(0);

    // B writes then reads back 0x20.
    set_b(1, 1, 32'h20, 32'hDEADBEEF);
    do_cycle(0);
    chk("wr20_we", obs_ram_we, 1);
    chk("wr20_addr", obs_ram_addr, 8);
    set_b(1, 0, 32'h20, 0);
    do_cycle(0);
    chk("rd20_data", b_rdata, 32'hDEADBEEF);
    set_b(0, 0, 0, 0);
    do_cycle(0);

    // Continuous contention: A x4, B x4, A x4.
    set_a(1, 0, 32'h100, 0);
    set_b(1, 0, 32'h200, 0);
    for (int i = 0; i < 12; i++) begin
      do_cycle(0);
      chk("burst_a_gnt", obs_a_gnt, (i < 4 || i >= 8));
    end
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    do_cycle(0);

    // B pulses its request for one cycle during A's second cycle.
    set_a(1, 0, 32'h40, 0);
    do_cycle(0);
    set_b(1, 0, 32'h44, 0);
    do_cycle(0);
    chk("pulse_b_gnt", obs_b_gnt, 0);
    chk("pulse_a_gnt", obs_a_gnt, 1);
    set_b(0, 0, 0, 0);
    do_cycle(0);
    set_a(0, 0, 0, 0);
    do_cycle(0);

    // Misaligned read of byte 0x6.
    set_a(1, 0, 32'h6, 0);
    do_cycle(0);
    chk("mis_gnt", obs_a_gnt, 1);
    if (ALIGN) begin
      chk("mis_err", a_err, 1);
      chk("mis_rvalid", a_rvalid, 0);
    end else begin
      chk("mis_addr", obs_ram_addr, 1);
      chk("mis_rvalid", a_rvalid, 1);
    end
    set_a(0, 0, 0, 0);
    do_cycle(0);

    // Reset during a granted read after A has used up a full burst.
    set_a(1, 0, 32'h80, 0);
    repeat (4) do_cycle(0);
    do_cycle(1);
    chk("rstmid_rvalid", a_rvalid, 0);
    set_b(1, 0, 32'h84, 0);
    do_cycle(0);
    chk("rstmid_contention_a", obs_a_gnt, 1);
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    do_cycle(0);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 63) << 2) | (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0),
            $urandom);
      set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 63) << 2) | (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0),
            $urandom);
      do_cycle($urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 32-bit data RAM between the CPU load/store unit (port A) and the UART program/data loader (port B). It sits directly in front of the data memory wrapper and drives its write enable, word address and write data. Read data is returned to whichever port issued the read. Arbitration is round-robin with a bounded ownership burst, so neither requester can starve the other.

## Interface
- ADDR_W, 14: RAM word-address width; byte address bits [ADDR_W+1:2] are used.
- DATA_W, 32: data width.
- MAX_BURST, 4: maximum consecutive granted cycles for one owner while the other port is requesting; legal range 1..15.

- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- a_req / b_req  in  1  access request, held until granted.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  32  byte address.
- a_wdata / b_wdata  in  DATA_W  write data.
- a_gnt / b_gnt  out  1  access accepted this cycle (combinational).
- a_rvalid / b_rvalid  out  1  read data valid (registered).
- a_rdata / b_rdata  out  DATA_W  read data (both driven from ram_rdata).
- a_err / b_err  out  1  misaligned access rejected (only with the macro in Configuration).
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid before the next rising edge after the address cycle.

## Operation
- State: owner ∈ {IDLE, OWN_A, OWN_B}; burst counter cnt (4 bits); last pointer ∈ {A, B}.
- Selection, evaluated combinationally each cycle:
  - No requests: no selection.
  - One request: that port is selected.
  - Both request, owner is OWN_X, cnt < MAX_BURST: X is selected.
  - Both request otherwise: the port that is not last is selected.
- gnt_X = 1 when X is selected. Exactly one access is issued per granted cycle.
- RAM mux: ram_we/ram_addr/ram_wdata come from the selected port. With no selection: ram_we=0, ram_addr=0, ram_wdata=0.
- Update at the clock edge:
  - Selected port equals the current owner: cnt increments, saturating at 15.
  - Selected port differs from the current owner: owner becomes the selected port, cnt=1, last becomes the selected port.
  - No selection: owner=IDLE, cnt=0; last is unchanged.
- rvalid_X is registered as gnt_X & !X_we. Writes produce no response.

## Timing
- Reset values: owner=IDLE, cnt=0, last=B (so A wins the first contention), a_rvalid=b_rvalid=0, a_err=b_err=0.
- Grant is in the same cycle as the request. Read data returns 1 cycle later with rvalid.
- Back-to-back accesses are supported: one access per cycle, and the requester may change address every granted cycle.
- Both ports requesting continuously: grants run MAX_BURST cycles to one port, then MAX_BURST cycles to the other.
- A port that drops req hands ownership over immediately; no idle cycle is inserted.
- Reset asserted mid-operation: a pending rvalid/err from the previous cycle is suppressed; all state returns to reset values.

## Configuration
- DMEM_ARB_ALIGN_CHECK_EN defined:
  - A selected access with addr[1:0] != 0 is granted but not issued (ram_we forced to 0).
  - err_X pulses for 1 cycle after the grant, and rvalid_X stays 0.
  - The access still counts toward cnt.
- Undefined:
  - addr[1:0] is ignored.
  - a_err and b_err are tied to 0.

## Structure
- Shared package dmem_arb_pkg holds:
  - the owner enum (IDLE/OWN_A/OWN_B);
  - the port ID encoding;
  - defaults for ADDR_W, DATA_W and MAX_BURST.
- One sub-module, dmem_arb_pick: purely combinational selection logic. Inputs: reqs, owner, cnt, last. Output: selected port.
- Top level holds the registers, the RAM mux and the response pipeline.

## Test plan
- Reset, then a_req read of 0x0000_0010 alone: a_gnt=1 in the same cycle, ram_addr=4; next cycle a_rvalid=1 and a_rdata=RAM[4].
- b_req write of 0xDEADBEEF to 0x20, then a read of 0x20: ram_we=1 with ram_addr=8; the following read returns 0xDEADBEEF; no b_rvalid on the write.
- Both requests held for 12 cycles with MAX_BURST=4: grant pattern A×4, B×4, A×4.
- A holds req while B requests for 1 cycle only, at A's cycle 2: B is not granted in that cycle; A stays granted.
- With the macro defined, a_req read of 0x0000_0006: a_gnt=1, ram_we=0, a_err=1 next cycle, a_rvalid=0. With the macro undefined: a normal read of word 1.
- Reset asserted the cycle after a granted read: a_rvalid stays 0; owner=IDLE; the next contention goes to A.
